// File: rtl/serial_magcomp_ctrl_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
//   start        : request; A/B sampled on the accepting edge
//   A, B         : unsigned operands
//   busy         : comparison in progress
//   done         : one-cycle completion pulse
//   AGB/AEB/ALB  : registered one-hot verdict (all zero = no result yet)
// master drives the request side, slave is the comparator.
interface serial_magcomp_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             AGB;
  logic             AEB;
  logic             ALB;

  modport master (
    output start, A, B,
    input  busy, done, AGB, AEB, ALB
  );

  modport slave (
    input  start, A, B,
    output busy, done, AGB, AEB, ALB
  );
endinterface

// File: rtl/serial_magcomp_ctrl.sv
// Bit-serial WIDTH-bit unsigned magnitude comparator.
// Loads A/B on an accepted start, then compares one bit pair per clock MSB-first.
// The first differing pair sets a sticky gt/lt flag. The verdict is registered
// on the edge that enters DONE and is held until the next result.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_magcomp_ctrl_if.slave (start, A, B in; busy, done, AGB, AEB, ALB out)
// Build option: define MAGCOMP_EARLY_EXIT_EN to finish on the first differing
// bit instead of always spending WIDTH cycles.
module serial_magcomp_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_magcomp_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             agb_q, agb_d;
  logic             aeb_q, aeb_d;
  logic             alb_q, alb_d;

  logic a_bit, b_bit, undecided, finish;

  assign a_bit     = a_q[WIDTH-1];
  assign b_bit     = b_q[WIDTH-1];
  assign undecided = ~gt_q & ~lt_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    agb_d   = agb_q;
    aeb_d   = aeb_q;
    alb_d   = alb_q;
    finish  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // DONE falls back to IDLE unless a new request arrives (back-to-back).
        state_d = StIdle;
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = CntW'(WIDTH - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Only the first difference counts; later bits leave the flags alone.
        if (undecided) begin
          gt_d = a_bit & ~b_bit;
          lt_d = ~a_bit & b_bit;
        end
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q - 1'b1;
        finish = (cnt_q == '0);
`ifdef MAGCOMP_EARLY_EXIT_EN
        if (undecided && (a_bit != b_bit)) finish = 1'b1;
`endif
        if (finish) begin
          state_d = StDone;
          agb_d   = gt_d;
          alb_d   = lt_d;
          aeb_d   = ~(gt_d | lt_d);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      agb_q   <= 1'b0;
      aeb_q   <= 1'b0;
      alb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      agb_q   <= agb_d;
      aeb_q   <= aeb_d;
      alb_q   <= alb_d;
    end
  end

  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
  assign bus.AGB  = agb_q;
  assign bus.AEB  = aeb_q;
  assign bus.ALB  = alb_q;

endmodule

// File: tb/tb_serial_magcomp_ctrl.sv
// Self-checking bench for serial_magcomp_ctrl (WIDTH=8) against a behavioural
// model: verdict from plain unsigned comparison, latency from the position of
// the highest differing bit.
module tb_serial_magcomp_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  serial_magcomp_ctrl_if #(.WIDTH(W)) bus ();

  serial_magcomp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model_verdict(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAGCOMP_EARLY_EXIT_EN
    logic [W-1:0] x;
    x = a ^ b;
    for (int k = 1; k <= W; k++) begin
      if (x >= (W'(1) << (W - k))) return k;
    end
    return W;
`else
    return W;
`endif
  endfunction

  function automatic logic [2:0] verdict();
    return {bus.AGB, bus.AEB, bus.ALB};
  endfunction

  // Waits for done after a load edge; counts edges from the load edge and any
  // cycle before done where busy dropped or the verdict moved.
  task automatic wait_done(output int lat, output int changes);
    logic [2:0] prev;
    prev    = verdict();
    lat     = -1;
    changes = 0;
    if (bus.busy !== 1'b1) changes++;
    for (int n = 1; n <= 3 * W; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (verdict() !== prev || bus.busy !== 1'b1) changes++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int changes);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    wait_done(lat, changes);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    tests_run++;
    if ({bus.busy, bus.done, verdict()} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected 00000", {bus.busy, bus.done, verdict()});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.done, verdict()} !== 5'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %b expected 00000", {bus.busy, bus.done, verdict()});
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, changes;
    do_op(a, b, lat, changes);
    tests_run++;
    if (lat !== model_latency(a, b)) begin
      tests_failed++;
      $display("FAIL %s_latency A=%h B=%h: got %0d expected %0d", name, a, b, lat,
               model_latency(a, b));
    end
    tests_run++;
    if (verdict() !== model_verdict(a, b)) begin
      tests_failed++;
      $display("FAIL %s_verdict A=%h B=%h: got %b expected %b", name, a, b, verdict(),
               model_verdict(a, b));
    end
    tests_run++;
    if (changes !== 0) begin
      tests_failed++;
      $display("FAIL %s_hold A=%h B=%h: got %0d bad shift cycles expected 0", name, a, b,
               changes);
    end
  endtask

  task automatic test_directed();
    check_op("equal_a5", 8'hA5, 8'hA5);
    check_op("gt_msb", 8'h80, 8'h7F);
    check_op("lt_low", 8'h01, 8'h02);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      unique case (i % 3)
        0: b = W'($urandom);
        1: b = a ^ (W'(1) << $urandom_range(W - 1, 0));
        default: b = a;
      endcase
      check_op("random", a, b);
    end
  endtask

  task automatic test_ignore_start();
    int dones, first;
    logic [2:0] v;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 8'd3;
    bus.B     = 8'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    first = -1;
    v     = '0;
    for (int n = 1; n <= W + 6; n++) begin
      if (n == 3) begin
        bus.start = 1'b1;
        bus.A     = 8'd9;
        bus.B     = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) begin
          first = n;
          v     = verdict();
        end
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL ignore_start_count: got %0d done pulses expected 1", dones);
    end
    tests_run++;
    if (first !== model_latency(8'd3, 8'd5)) begin
      tests_failed++;
      $display("FAIL ignore_start_latency: got %0d expected %0d", first,
               model_latency(8'd3, 8'd5));
    end
    tests_run++;
    if (v !== model_verdict(8'd3, 8'd5)) begin
      tests_failed++;
      $display("FAIL ignore_start_verdict: got %b expected %b", v, model_verdict(8'd3, 8'd5));
    end
  endtask

  task automatic test_back_to_back();
    int lat, changes;
    do_op(8'h20, 8'h40, lat, changes);
    tests_run++;
    if (verdict() !== 3'b001) begin
      tests_failed++;
      $display("FAIL b2b_first_verdict: got %b expected 001", verdict());
    end
    // Still inside the DONE cycle: request again with no IDLE gap.
    bus.start = 1'b1;
    bus.A     = 8'hFF;
    bus.B     = 8'h00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_no_idle: got busy/done %b expected 10", {bus.busy, bus.done});
    end
    wait_done(lat, changes);
    tests_run++;
    if (lat !== model_latency(8'hFF, 8'h00)) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d expected %0d", lat, model_latency(8'hFF, 8'h00));
    end
    tests_run++;
    if (verdict() !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_verdict: got %b expected 100", verdict());
    end
    tests_run++;
    if (changes !== 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got %0d bad shift cycles expected 0", changes);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 8'h55;
    bus.B     = 8'h55;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 0; n < 4; n++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, verdict()} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %b expected 00000", {bus.busy, bus.done, verdict()});
    end
    dones = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < W + 2; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
    end
    check_op("after_reset", 8'h10, 8'h10);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
